// File: rtl/result_fifo_if.sv
// Handshake bundle between the result producer/consumer and result_fifo.
// The master side drives writes, pops and error clears; the slave side
// (the FIFO) returns the head entry and its status.
interface result_fifo_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] in_data;
   logic             wr_en;
   logic             rd_en;
   logic             clr_err;
   logic [WIDTH-1:0] out_data;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output in_data, wr_en, rd_en, clr_err,
      input  out_data, empty, full, count, overflow, underflow
   );

   modport slave (
      input  in_data, wr_en, rd_en, clr_err,
      output out_data, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through buffer for the registered adder result.
// The head entry is always presented on out_data (0 while empty); overflow
// and underflow are latched in sticky flags until clr_err or reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   result_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   logic             empty;
   logic             full;
   logic             wr_acc;
   logic             rd_acc;
   logic             ovf_evt;
   logic             udf_evt;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));

   // A full FIFO still takes a write when the same cycle pops the head.
   assign wr_acc  = bus.wr_en && (!full || bus.rd_en);
   assign rd_acc  = bus.rd_en && !empty;
   assign ovf_evt = bus.wr_en && full && !bus.rd_en;
   assign udf_evt = bus.rd_en && empty;

   // Storage array; cleared on reset so stale results never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_acc) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointers and occupancy move together so status has no extra latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a fresh error outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)          overflow  <= 1'b1;
         else if (bus.clr_err) overflow  <= 1'b0;
         if (udf_evt)          underflow <= 1'b1;
         else if (bus.clr_err) underflow <= 1'b0;
      end
   end

   assign bus.out_data  = empty ? '0 : mem[rd_ptr];
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = count;
   assign bus.overflow  = overflow;
   assign bus.underflow = underflow;
endmodule

// File: tb/tb_result_fifo.sv
// Bench for result_fifo: directed vector table, hand-built reset sequences,
// and a randomized run checked against a queue-based reference model.
module tb_result_fifo;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b1;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

   result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       wr;
      bit       rd;
      bit       clr;
      bit [3:0] din;
      bit [3:0] eout;
      bit       eempty;
      bit       efull;
      bit [2:0] ecnt;
      bit       eovf;
      bit       eudf;
   } vec_t;

   vec_t tbl[$];

   // reference model: contents as a queue, flags as plain bits
   bit [3:0] mq[$];
   bit       m_ovf;
   bit       m_udf;

   function automatic void add(bit wr, bit rd, bit clr, bit [3:0] din, bit [3:0] eout,
                               bit eempty, bit efull, bit [2:0] ecnt, bit eovf, bit eudf);
      vec_t v;
      v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.eout = eout;
      v.eempty = eempty; v.efull = efull; v.ecnt = ecnt; v.eovf = eovf; v.eudf = eudf;
      tbl.push_back(v);
   endfunction

   task automatic chk(string tag, string fld, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, exp);
      end
   endtask

   task automatic check_all(string tag, bit [3:0] eout, bit eempty, bit efull,
                            bit [2:0] ecnt, bit eovf, bit eudf);
      chk(tag, "out_data",  int'(bus.out_data),  int'(eout));
      chk(tag, "empty",     int'(bus.empty),     int'(eempty));
      chk(tag, "full",      int'(bus.full),      int'(efull));
      chk(tag, "count",     int'(bus.count),     int'(ecnt));
      chk(tag, "overflow",  int'(bus.overflow),  int'(eovf));
      chk(tag, "underflow", int'(bus.underflow), int'(eudf));
   endtask

   task automatic apply(bit wr, bit rd, bit clr, bit [3:0] din);
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.clr_err = clr;
      bus.in_data = din;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(bit wr, bit rd, bit clr, bit [3:0] din);
      int  n = mq.size();
      bit  was_full = (n == DEPTH);
      bit  was_empty = (n == 0);
      if (rd && !was_empty) void'(mq.pop_front());
      if (wr && (!was_full || rd)) mq.push_back(din);
      if (wr && was_full && !rd) m_ovf = 1'b1;
      else if (clr)              m_ovf = 1'b0;
      if (rd && was_empty)       m_udf = 1'b1;
      else if (clr)              m_udf = 1'b0;
   endtask

   task automatic check_model(string tag);
      bit [3:0] eout = (mq.size() == 0) ? 4'h0 : mq[0];
      check_all(tag, eout, mq.size() == 0, mq.size() == DEPTH,
                3'(mq.size()), m_ovf, m_udf);
   endtask

   task automatic do_reset();
      bus.wr_en = 0; bus.rd_en = 0; bus.clr_err = 0; bus.in_data = '0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
   endtask

   initial begin
      bus.wr_en = 0; bus.rd_en = 0; bus.clr_err = 0; bus.in_data = '0;
      rst_n = 1'b0;
      #2 check_all("in_reset", 4'h0, 1, 0, 3'd0, 0, 0);
      #3 rst_n = 1'b1;

      // reset then idle
      for (int i = 0; i < 3; i++) apply(0, 0, 0, 4'h0);
      check_all("idle", 4'h0, 1, 0, 3'd0, 0, 0);

      //   wr rd clr din   out  emp full cnt ovf udf
      add(1, 0, 0, 4'hA, 4'hA, 0, 0, 3'd1, 0, 0);
      add(1, 0, 0, 4'h1, 4'hA, 0, 0, 3'd2, 0, 0);
      add(1, 0, 0, 4'h2, 4'hA, 0, 0, 3'd3, 0, 0);
      add(1, 0, 0, 4'h5, 4'hA, 0, 1, 3'd4, 0, 0);
      add(1, 0, 0, 4'hF, 4'hA, 0, 1, 3'd4, 1, 0);
      add(1, 0, 1, 4'hE, 4'hA, 0, 1, 3'd4, 1, 0);
      add(0, 1, 0, 4'h0, 4'h1, 0, 0, 3'd3, 1, 0);
      add(0, 1, 0, 4'h0, 4'h2, 0, 0, 3'd2, 1, 0);
      add(0, 1, 0, 4'h0, 4'h5, 0, 0, 3'd1, 1, 0);
      add(0, 1, 0, 4'h0, 4'h0, 1, 0, 3'd0, 1, 0);
      add(0, 0, 1, 4'h0, 4'h0, 1, 0, 3'd0, 0, 0);
      add(1, 1, 0, 4'h6, 4'h6, 0, 0, 3'd1, 0, 1);
      add(0, 0, 1, 4'h0, 4'h6, 0, 0, 3'd1, 0, 0);
      add(0, 1, 0, 4'h0, 4'h0, 1, 0, 3'd0, 0, 0);
      add(1, 0, 0, 4'hA, 4'hA, 0, 0, 3'd1, 0, 0);
      add(1, 0, 0, 4'h1, 4'hA, 0, 0, 3'd2, 0, 0);
      add(1, 0, 0, 4'h2, 4'hA, 0, 0, 3'd3, 0, 0);
      add(1, 0, 0, 4'h5, 4'hA, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'h7, 4'h1, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'h8, 4'h2, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'h9, 4'h5, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'hB, 4'h7, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'hC, 4'h8, 0, 1, 3'd4, 0, 0);
      add(1, 1, 0, 4'hD, 4'h9, 0, 1, 3'd4, 0, 0);
      add(0, 1, 0, 4'h0, 4'hB, 0, 0, 3'd3, 0, 0);
      add(0, 1, 0, 4'h0, 4'hC, 0, 0, 3'd2, 0, 0);
      add(0, 1, 0, 4'h0, 4'hD, 0, 0, 3'd1, 0, 0);
      add(0, 1, 0, 4'h0, 4'h0, 1, 0, 3'd0, 0, 0);
      add(0, 1, 1, 4'h0, 4'h0, 1, 0, 3'd0, 0, 1);
      add(0, 0, 1, 4'h0, 4'h0, 1, 0, 3'd0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
         check_all($sformatf("vec%0d", i), tbl[i].eout, tbl[i].eempty, tbl[i].efull,
                   tbl[i].ecnt, tbl[i].eovf, tbl[i].eudf);
      end

      // async reset between edges with three entries buffered
      apply(1, 0, 0, 4'h4);
      apply(1, 0, 0, 4'h5);
      apply(1, 1, 0, 4'h6);
      apply(1, 0, 0, 4'h7);
      check_all("pre_areset", 4'h5, 0, 0, 3'd3, 0, 0);
      bus.wr_en = 0; bus.rd_en = 0;
      #3 rst_n = 1'b0;
      #1 check_all("areset", 4'h0, 1, 0, 3'd0, 0, 0);
      #2 rst_n = 1'b1;
      apply(1, 0, 0, 4'h3);
      check_all("post_areset", 4'h3, 0, 0, 3'd1, 0, 0);

      // randomized traffic against the reference model, with shifting bias
      do_reset();
      for (int ph = 0; ph < 3; ph++) begin
         int wprob = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
         for (int i = 0; i < 200; i++) begin
            bit       wr  = ($urandom_range(0, 99) < wprob);
            bit       rd  = ($urandom_range(0, 99) < (100 - wprob));
            bit       clr = ($urandom_range(0, 99) < 6);
            bit [3:0] din = 4'($urandom_range(0, 15));
            model_step(wr, rd, clr, din);
            apply(wr, rd, clr, din);
            check_model($sformatf("rnd%0d_%0d", ph, i));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
